// File: rtl/pipe_pkg.sv
// Shared constants and state type for the elastic stage registers at each
// pipeline boundary of the ARMv8 datapath.
package pipe_pkg;

  localparam int unsigned DATA_W_DEF  = 160;
  localparam int unsigned IF_ID_W     = 160;
  localparam int unsigned ID_EX_W     = 320;
  localparam int unsigned EX_MEM_W    = 232;
  localparam int unsigned MEM_WB_W    = 200;
  localparam int unsigned STALL_CNT_W = 32;

  // Encoding is {main_valid, skid_valid}; 2'b01 is unreachable.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_MAIN  = 2'b10,
    ST_FULL  = 2'b11
  } stage_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable; holds at all-ones until reset.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en && (count_q != '1)) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage.sv
// Elastic pipeline register with a 2-entry skid buffer, synchronous flush
// and a saturating downstream-stall counter.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = STALL_CNT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_count
);

  stage_state_e      state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              main_valid, skid_valid;
  logic              accept, drain;

  assign main_valid = (state_q == ST_MAIN) || (state_q == ST_FULL);
  assign skid_valid = (state_q == ST_FULL);

  assign accept = in_valid && in_ready;
  assign drain  = main_valid && out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;
    // Flush only clears the valid state; data registers are don't-care then.
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d     = ST_MAIN;
            main_data_d = in_data;
          end
        end
        ST_MAIN: begin
          if (drain && accept) begin
            main_data_d = in_data;
          end else if (drain) begin
            state_d = ST_EMPTY;
          end else if (accept) begin
            state_d     = ST_FULL;
            skid_data_d = in_data;
          end
        end
        ST_FULL: begin
          if (drain) begin
            state_d     = ST_MAIN;
            main_data_d = skid_data_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
    end
  end

  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;
  assign out_data  = main_data_q;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .en    (main_valid && !out_ready),
    .count (stall_count)
  );

endmodule

// File: tb/tb_pipe_stage.sv
// Bench for pipe_stage: directed scenarios plus random traffic checked
// against a queue-based model of the stage.
module tb_pipe_stage;

  localparam int unsigned DW = 160;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b0;
  logic          in_ready, out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [31:0]   stall_count;

  logic          in_ready4, out_valid4;
  logic [DW-1:0] out_data4;
  logic [1:0]    occupancy4;
  logic [3:0]    stall_count4;

  int unsigned   n_tests = 0;
  int unsigned   n_fail  = 0;
  logic [DW-1:0] q[$];
  longint unsigned stall_m = 0;

  always #5 clock = ~clock;

  pipe_stage #(.DATA_W(DW), .CNT_W(32)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .occupancy(occupancy), .stall_count(stall_count)
  );

  pipe_stage #(.DATA_W(DW), .CNT_W(4)) dut4 (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready4),
    .out_valid(out_valid4), .out_data(out_data4), .out_ready(out_ready),
    .occupancy(occupancy4), .stall_count(stall_count4)
  );

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    longint unsigned s32, s4;
    s32 = (stall_m > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : stall_m;
    s4  = (stall_m > 15) ? 15 : stall_m;
    check("out_valid", DW'(out_valid), DW'(q.size() > 0));
    if (q.size() > 0) check("out_data", out_data, q[0]);
    check("in_ready", DW'(in_ready), DW'(q.size() < 2));
    check("occupancy", DW'(occupancy), DW'(q.size()));
    check("stall_count", DW'(stall_count), DW'(s32));
    check("stall_count4", DW'(stall_count4), DW'(s4));
    check("state_01", DW'(!out_valid && occupancy != 2'd0), '0);
  endtask

  task automatic model_edge();
    bit acc, drn;
    acc = in_valid && (q.size() < 2);
    drn = (q.size() > 0) && out_ready;
    if ((q.size() > 0) && !out_ready) stall_m++;
    if (flush) q.delete();
    else begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(in_data);
    end
  endtask

  task automatic step(input bit v, input logic [DW-1:0] d, input bit r, input bit f);
    in_valid = v; in_data = d; out_ready = r; flush = f;
    @(negedge clock);
    check_outputs();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  // Assert reset mid-cycle and check it acts without a clock edge.
  task automatic do_reset();
    in_valid = 1'b0; flush = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_out_valid", DW'(out_valid), '0);
    check("rst_in_ready", DW'(in_ready), DW'(1));
    check("rst_occupancy", DW'(occupancy), '0);
    check("rst_stall_count", DW'(stall_count), '0);
    check("rst_out_data", out_data, '0);
    q.delete();
    stall_m = 0;
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  initial begin
    logic [31:0] seq;
    #1;
    do_reset();

    for (int i = 1; i <= 8; i++) begin
      step(1'b1, DW'(i), 1'b1, 1'b0);
      check("stream_data", out_data, DW'(i));
      check("stream_occ_le1", DW'(occupancy > 2'd1), '0);
    end
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    step(1'b1, DW'(32'hA), 1'b0, 1'b0);
    step(1'b1, DW'(32'hB), 1'b0, 1'b0);
    check("skid_occ", DW'(occupancy), DW'(2));
    check("skid_in_ready", DW'(in_ready), '0);
    check("skid_head", out_data, DW'(32'hA));
    step(1'b0, '0, 1'b1, 1'b0);
    check("skid_second", out_data, DW'(32'hB));
    check("skid_recover", DW'(in_ready), DW'(1));
    step(1'b0, '0, 1'b1, 1'b0);

    step(1'b1, DW'(32'hA2), 1'b0, 1'b0);
    step(1'b1, DW'(32'hB2), 1'b0, 1'b0);
    step(1'b1, DW'(32'hC), 1'b0, 1'b1);
    check("flush_valid", DW'(out_valid), '0);
    check("flush_occ", DW'(occupancy), '0);
    check("flush_ready", DW'(in_ready), DW'(1));
    step(1'b1, DW'(32'hD), 1'b1, 1'b0);
    check("post_flush_accept", out_data, DW'(32'hD));
    step(1'b1, DW'(32'hE), 1'b1, 1'b0);
    step(1'b1, DW'(32'hF), 1'b1, 1'b1);
    check("flush_drop_in", DW'(out_valid), '0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("flush_no_ghost", DW'(out_valid), '0);

    do_reset();
    step(1'b1, DW'(32'h55), 1'b1, 1'b0);
    repeat (10) step(1'b0, '0, 1'b0, 1'b0);
    check("stall10", DW'(stall_count), DW'(10));
    repeat (10) step(1'b0, '0, 1'b0, 1'b0);
    check("stall20", DW'(stall_count), DW'(20));
    check("stall_sat4", DW'(stall_count4), DW'(15));

    step(1'b1, DW'(32'h66), 1'b0, 1'b0);
    do_reset();

    seq = 32'h100;
    for (int i = 0; i < 10000; i++) begin
      seq++;
      step($urandom_range(0, 99) < 60,
           {$urandom, $urandom, $urandom, $urandom, seq},
           $urandom_range(0, 99) < 60,
           $urandom_range(0, 99) < 3);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage.md
# pipe_stage

Parametrised elastic pipeline register for the ARMv8 datapath, successor to the fixed IF_ID/ID_EX registers with a single write-enable. It carries an arbitrary-width stage bundle (PC, PC+4, instruction, control bits, operands) between two pipeline stages with a valid/ready handshake, a 2-entry skid buffer, synchronous flush for branch redirect, and a saturating stall counter for performance measurement. One instance sits at each stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).

## Interface
- DATA_W, 160, width of the stage bundle (default: PC 64 + PC+4 64 + instruction 32)
- CNT_W, 32, width of the stall counter
- clock  in  1  single clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- flush  in  1  synchronous squash of everything held and of the same-cycle input
- in_valid  in  1  upstream stage presents a bundle
- in_data  in  DATA_W  upstream bundle
- in_ready  out  1  stage can accept; driven directly from a flop
- out_valid  out  1  bundle available to downstream
- out_data  out  DATA_W  bundle to downstream
- out_ready  in  1  downstream accepts
- occupancy  out  2  entries held: 0, 1 or 2
- stall_count  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

## Operation
- Storage: main entry (main_valid, main_data) drives the outputs; skid entry (skid_valid, skid_data) absorbs one bundle when downstream stalls.
- in_ready = !skid_valid (registered, no combinational path from out_ready).
- out_valid = main_valid; out_data = main_data; occupancy = main_valid + skid_valid.
- Accept = in_valid & in_ready; Drain = main_valid & out_ready.
- Next state, flush=0:
  - Empty, Accept: input -> main.
  - Main only, Drain & Accept: input -> main (full throughput).
  - Main only, Drain & !Accept: main empties.
  - Main only, !Drain & Accept: input -> skid; in_ready drops next cycle.
  - Both full, Drain: skid -> main, skid empties; no accept possible (in_ready=0).
  - Both full, !Drain: hold.
- Order preserved: main always older than skid.
- flush=1: main_valid and skid_valid cleared next edge regardless of Accept/Drain; a same-cycle accepted input is discarded. A Drain in the flush cycle still counts as a completed transfer downstream. Data registers keep old contents (don't-care while invalid).
- Stall counter: increments by 1 each cycle with out_valid & !out_ready, including the flush cycle; holds at 2^CNT_W-1; cleared only by reset.
- State encoding: {main_valid, skid_valid} in {00, 10, 11}; 01 is illegal and must never be reached.

## Timing
- Reset values: out_valid=0, out_data=0, in_ready=1, occupancy=0, stall_count=0; skid_data=0.
- Reset is asynchronous on assert; deassertion is synchronised by the integrator. Reset mid-transfer drops all held bundles.
- Latency in -> out: 1 cycle (accepted at edge N, out_valid at N+1).
- Throughput: 1 bundle/cycle while out_ready=1.
- After downstream stalls with main full and one bundle accepted into skid, in_ready=0 from the next cycle until the skid drains; recovery takes 1 cycle after out_ready returns.
- After flush at edge N: out_valid=0 and in_ready=1 at N+1; a new bundle can be accepted in cycle N+1.

## Structure
- Shared package pipe_pkg: DATA_W default, per-boundary bundle widths (IF_ID_W, ID_EX_W, EX_MEM_W, MEM_WB_W), and the stall-counter width constant.
- One natural sub-module: sat_counter (CNT_W-wide saturating incrementer with enable). The skid logic stays inline.
- Instances per boundary are configured only via DATA_W; no per-stage logic inside the block.

## Test plan
- Reset while holding 2 entries -> out_valid=0, in_ready=1, occupancy=0, stall_count=0 immediately, without waiting for a clock edge.
- Stream 0x1..0x8 with out_ready=1 -> outputs 0x1..0x8 in order, one per cycle, 1-cycle latency, occupancy never above 1.
- Send A, B with out_ready=0 -> occupancy=2, in_ready=0, out_data=A; raise out_ready -> A then B, in_ready=1 one cycle after A drains.
- occupancy=2, assert flush with in_valid=1 carrying C -> next cycle out_valid=0, occupancy=0; C never appears on out_data.
- Hold out_valid=1, out_ready=0 for 10 cycles -> stall_count=10; with CNT_W=4, 20 stalled cycles -> stall_count=15.
- Random in_valid/out_ready/flush for 10k cycles against a scoreboard -> no loss, no duplication, order kept, {main,skid}=01 never observed.
